// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings, the
// default table index width, the shadow-pipeline slot layout and the
// saturating counter update.
package bp_pkg;

  // Default log2 of the counter-table depth.
  localparam int unsigned IdxWDefault = 6;

  // 2-bit saturating counter encodings.
  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // One shadow-pipeline slot. The idx field is sized for IdxWDefault, so the
  // predictor is built with IDX_W equal to that default.
  typedef struct packed {
    logic                   valid;
    logic                   pred;
    logic [IdxWDefault-1:0] idx;
  } shadow_slot_t;

  // Saturating counter step: never wraps past ST or below SNT.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'b01;
    end else begin
      return (cnt == SNT) ? SNT : cnt - 2'b01;
    end
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2^IDX_W two-bit saturating counters with one combinational read
// port and one saturating-update write port. Async active-high reset loads
// every counter with CNT_INIT.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = IdxWDefault,
  parameter logic [1:0]  CNT_INIT = WNT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int Entries = 1 << IDX_W;

  logic [1:0] cnt_q [Entries];

  // Read is not bypassed: a same-cycle update is seen only on the next cycle.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  // Counter array: reset to CNT_INIT, train one entry per resolution.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= sat_update(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with an ID->EX->MEM shadow pipeline that aligns
// each prediction with the datapath's MEM-stage resolution.
// Optional macro BP_GSHARE_EN: XOR the PC index with a non-speculative
// global history register (gshare). Undefined: plain bimodal indexing.
`ifndef FLUSH_ALL
`define FLUSH_ALL 4'hF
`endif

module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = IdxWDefault,
  parameter logic [1:0]  CNT_INIT = WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic        id_is_branch,
  input  logic        id_jump_early,
  input  logic [3:0]  hazard_signal,
  input  logic        branch_resolved,
  input  logic        actual_taken,
  output logic        predict_taken,
  output logic        jump_taken
);

  logic [IDX_W-1:0] idx;
  logic [1:0]       rd_cnt;
  shadow_slot_t     ex_d, ex_q, mem_q;

  // PC bits outside the word-aligned index field do not affect prediction.
  logic unused_pc;
  assign unused_pc = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // Global history shifts in resolved outcomes only (non-speculative).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (branch_resolved) begin
      ghr_q <= {ghr_q[IDX_W-2:0], actual_taken};
    end
  end

  assign idx = id_pc[IDX_W+1:2] ^ ghr_q;
`else
  assign idx = id_pc[IDX_W+1:2];
`endif

  bp_counter_table #(
    .IDX_W   (IDX_W),
    .CNT_INIT(CNT_INIT)
  ) u_table (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_idx_i  (idx),
    .rd_cnt_o  (rd_cnt),
    .wr_en_i   (branch_resolved),
    .wr_idx_i  (mem_q.idx),
    .wr_taken_i(actual_taken)
  );

  // ID-stage lookup and the slot it launches into EX.
  always_comb begin
    predict_taken = id_jump_early | (id_is_branch & rd_cnt[1]);
    ex_d          = '0;
    ex_d.valid    = id_is_branch | id_jump_early;
    ex_d.pred     = predict_taken;
    ex_d.idx      = idx;
  end

  // Shadow pipeline; a full flush empties both slots alongside the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (hazard_signal == `FLUSH_ALL) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
    end
  end

  assign jump_taken = mem_q.valid & mem_q.pred;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed steps from the test plan
// followed by randomized traffic, all checked against a behavioural model
// (integer counters, history integer, queue of in-flight predictions).
`ifndef FLUSH_ALL
`define FLUSH_ALL 4'hF
`endif

module tb_branch_predictor;

  localparam int Entries = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_pc = 32'h100;
  logic        id_is_branch = 1'b1;
  logic        id_jump_early = 1'b0;
  logic [3:0]  hazard_signal = 4'h0;
  logic        branch_resolved = 1'b0;
  logic        actual_taken = 1'b0;
  logic        predict_taken;
  logic        jump_taken;

  int checks = 0;
  int failures = 0;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .id_pc          (id_pc),
    .id_is_branch   (id_is_branch),
    .id_jump_early  (id_jump_early),
    .hazard_signal  (hazard_signal),
    .branch_resolved(branch_resolved),
    .actual_taken   (actual_taken),
    .predict_taken  (predict_taken),
    .jump_taken     (jump_taken)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef struct {
    bit v;
    bit p;
    int idx;
  } pred_s;

  int    cnt_m [Entries];
  int    ghr_m;
  pred_s inflight [$];  // front = prediction now in MEM

  function automatic int idx_of(input logic [31:0] pc);
    int i;
    i = int'(pc[31:2]) % Entries;
`ifdef BP_GSHARE_EN
    i = i ^ ghr_m;
`endif
    return i;
  endfunction

  task automatic model_reset();
    pred_s z;
    z = '{v: 1'b0, p: 1'b0, idx: 0};
    for (int i = 0; i < Entries; i++) cnt_m[i] = 1;
    ghr_m = 0;
    inflight.delete();
    inflight.push_back(z);
    inflight.push_back(z);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One cycle: drive ID/MEM inputs, check both outputs, then advance the model
  // across the rising edge. Entered and left at posedge+1.
  task automatic cyc(input logic [31:0] pc, input bit br, input bit je, input logic [3:0] hz,
                     input bit res, input bit act, output bit pred_o, output bit jt_o);
    bit    exp_pred;
    bit    exp_jt;
    pred_s n;
    int    t;
    id_pc = pc; id_is_branch = br; id_jump_early = je;
    hazard_signal = hz; branch_resolved = res; actual_taken = act;
    #1;
    exp_pred = je | (br & (cnt_m[idx_of(pc)] >= 2));
    exp_jt   = inflight[0].v & inflight[0].p;
    chk("predict_taken", predict_taken, exp_pred);
    chk("jump_taken", jump_taken, exp_jt);
    pred_o = predict_taken;
    jt_o   = jump_taken;
    n = '{v: br | je, p: exp_pred, idx: idx_of(pc)};
    @(posedge clk);
    if (res) begin
      t = inflight[0].idx;
      cnt_m[t] = act ? ((cnt_m[t] < 3) ? cnt_m[t] + 1 : 3) : ((cnt_m[t] > 0) ? cnt_m[t] - 1 : 0);
      ghr_m = ((ghr_m << 1) | int'(act)) % Entries;
    end
    if (hz == `FLUSH_ALL) begin
      model_reset_slots();
    end else begin
      void'(inflight.pop_front());
      inflight.push_back(n);
    end
    #1;
  endtask

  task automatic model_reset_slots();
    pred_s z;
    z = '{v: 1'b0, p: 1'b0, idx: 0};
    inflight.delete();
    inflight.push_back(z);
    inflight.push_back(z);
  endtask

  // Asynchronous reset pulse of one edge; outputs checked while rst is high.
  task automatic do_reset();
    bit exp_pred;
    rst = 1'b1;
    model_reset();
    branch_resolved = 1'b0;
    #1;
    exp_pred = id_jump_early | (id_is_branch & (cnt_m[idx_of(id_pc)] >= 2));
    chk("reset_jump_taken", jump_taken, 1'b0);
    chk("reset_predict_taken", predict_taken, exp_pred);
    @(posedge clk);
    #1;
    chk("reset_hold_jump_taken", jump_taken, 1'b0);
    rst = 1'b0;
  endtask

  bit p, j;
  logic [31:0] rpc;
  bit rbr, rje, rres, ract;
  logic [3:0] rhz;

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // Reset then lookup of 0x100: counter 01 -> not taken.
    do_reset();
    cyc(32'h100, 1, 0, 4'h0, 0, 0, p, j);
    chk("reset_lookup_0x100", p, 1'b0);
    cyc(32'h100, 1, 0, 4'h0, 0, 0, p, j);

    // Train taken 4x: 01->10->11->11->11, then not-taken 4x down to 00.
    for (int i = 0; i < 4; i++) cyc(32'h100, 1, 0, 4'h0, 1, 1, p, j);
    cyc(32'h100, 1, 0, 4'h0, 0, 0, p, j);
`ifndef BP_GSHARE_EN
    chk("sat_taken_pred", p, 1'b1);
`endif
    for (int i = 0; i < 4; i++) cyc(32'h100, 1, 0, 4'h0, 1, 0, p, j);
    cyc(32'h100, 1, 0, 4'h0, 0, 0, p, j);
`ifndef BP_GSHARE_EN
    chk("sat_not_taken_pred", p, 1'b0);
`endif

    // Alignment: 0x200 trained to 11, branch at N, non-branch at N+1.
    for (int i = 0; i < 3; i++) cyc(32'h200, 1, 0, 4'h0, 1, 1, p, j);
    cyc(32'h200, 1, 0, 4'h0, 0, 0, p, j);
    cyc(32'h0, 0, 0, 4'h0, 0, 0, p, j);
    cyc(32'h0, 0, 0, 4'h0, 0, 0, p, j);
`ifndef BP_GSHARE_EN
    chk("align_n_plus_2", j, 1'b1);
`endif
    cyc(32'h0, 0, 0, 4'h0, 0, 0, p, j);
    chk("align_n_plus_3", j, 1'b0);

    // Same-index collision on entry 5 (pc 0x14): update not bypassed.
    do_reset();
    cyc(32'h14, 1, 0, 4'h0, 0, 0, p, j);
    cyc(32'h0, 0, 0, 4'h0, 0, 0, p, j);
    cyc(32'h14, 1, 0, 4'h0, 1, 1, p, j);
    chk("collision_same_cycle", p, 1'b0);
    cyc(32'h14, 1, 0, 4'h0, 0, 0, p, j);
`ifndef BP_GSHARE_EN
    chk("collision_next_cycle", p, 1'b1);
`endif

    // Flush one cycle after a taken prediction; training on the flush edge.
    cyc(32'h14, 1, 0, `FLUSH_ALL, 1, 1, p, j);
    cyc(32'h14, 1, 0, 4'h0, 0, 0, p, j);
    chk("flush_jump_taken", j, 1'b0);
    cyc(32'h14, 1, 0, 4'h0, 0, 0, p, j);
    cyc(32'h14, 1, 0, 4'h0, 1, 0, p, j);
    cyc(32'h14, 1, 0, 4'h0, 0, 0, p, j);
`ifndef BP_GSHARE_EN
    chk("flush_still_trains", p, 1'b1);
`endif

    // Jump resolved in ID predicts taken regardless of the table.
    cyc(32'h100, 0, 1, 4'h0, 0, 0, p, j);
    chk("jump_early_pred", p, 1'b1);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 97 == 96) begin
        do_reset();
      end else begin
        rpc  = $urandom() & 32'h0000_F03C;
        rbr  = bit'($urandom_range(0, 1));
        rje  = !rbr && ($urandom_range(0, 7) == 0);
        rhz  = 4'($urandom_range(0, 15));
        rres = ($urandom_range(0, 2) == 0);
        ract = bit'($urandom_range(0, 1));
        cyc(rpc, rbr, rje, rhz, rres, ract, p, j);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Produces the `jump_taken` prediction that the datapath consumes, and consumes the datapath's `branch_resolved` / `actual_taken` resolution signals.
- Holds a table of 2-bit saturating counters indexed by PC, looked up at ID.
- Carries each prediction down an ID→EX→MEM shadow pipeline so that it lines up with the datapath's MEM-stage resolution.
- Trains the counter on resolution.

Parameters:
IDX_W, 6, log2 of counter-table entries (64 entries)
CNT_INIT, 2'b01, reset value of every counter (weakly not-taken)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
id_pc  input  32  PC of the instruction currently in ID
id_is_branch  input  1  ID instruction is a conditional branch
id_jump_early  input  1  ID instruction is a JAL whose target is resolved in ID
hazard_signal  input  4  pipeline hazard code; `FLUSH_ALL clears EX/MEM slots
branch_resolved  input  1  MEM-stage branch resolved this cycle
actual_taken  input  1  resolved direction of the MEM-stage branch
predict_taken  output  1  ID-stage prediction to fetch redirect logic (combinational)
jump_taken  output  1  prediction carried with the MEM-stage instruction (registered path)

Behaviour:
- Index: idx = id_pc[IDX_W+1:2], or the hashed index when the optional feature is enabled.
- Lookup:
  - predict_taken = id_jump_early | (id_is_branch & table[idx][1]).
  - Purely combinational from the current table.
  - A same-cycle update to the same entry is NOT bypassed; the lookup sees the pre-update value.
- Shadow pipeline: two slots, EX and MEM, each holding {valid, pred, idx}.
  - Each posedge, EX <= {id_is_branch|id_jump_early, predict_taken, idx} and MEM <= EX.
  - If hazard_signal == `FLUSH_ALL: EX and MEM slots <= 0 on that edge, in the same cycle the datapath clears its EX/MEM control.
- Output: jump_taken = MEM.valid & MEM.pred. Zero whenever the MEM slot is empty or flushed.
- Update:
  - When branch_resolved == 1 at a posedge, train table[MEM.idx].
  - actual_taken=1: counter saturating-increments (max 2'b11).
  - actual_taken=0: counter saturating-decrements (min 2'b00).
  - Training happens even if `FLUSH_ALL is asserted on the same edge, because the resolving branch causes the flush.
  - Jumps never train, since branch_resolved is 0 for jumps.
- Saturation:
  - 2'b11 + taken stays 2'b11.
  - 2'b00 + not-taken stays 2'b00.
  - No wrap-around.
- Reset (async, rst=1):
  - All counters <= CNT_INIT.
  - Both slots <= 0.
  - predict_taken follows the table and jump_taken = 0 immediately.
  - Reset mid-operation discards in-flight predictions; no training occurs while rst is high.
- Latency: prediction available same cycle in ID; appears on jump_taken exactly 2 cycles later (MEM), absent flush.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register (GHR), reset 0.
  - idx = id_pc[IDX_W+1:2] ^ GHR.
  - On each branch_resolved edge, GHR <= {GHR[IDX_W-2:0], actual_taken}, updated non-speculatively.
  - The stored MEM.idx (the hashed value) is used for training.
- Undefined: no GHR; idx is the plain PC bits (bimodal).

Decomposition:
- Shared package bp_pkg holds:
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Index-width default.
  - The shadow-slot struct layout.
- `FLUSH_ALL comes from the existing hazard-code definitions.
- One sub-module, bp_counter_table, owns:
  - The 2^IDX_W×2-bit flop array with async reset.
  - The combinational read port.
  - The saturating-update write port.
- branch_predictor owns the index hash, GHR and shadow pipeline.

Test Plan:
- Reset then lookup: rst pulse; id_pc=0x100, id_is_branch=1 -> predict_taken=0 (counter 01); jump_taken=0 during and after reset.
- Training/saturation: resolve a branch at pc 0x100 taken 4× -> counter 01→10→11→11; next lookup of 0x100 gives predict_taken=1; then 4× not-taken -> 00, predict_taken=0.
- Alignment: present branch at 0x200 with counter=11 at cycle N -> jump_taken=1 exactly at cycle N+2; non-branch at N+1 -> jump_taken=0 at N+3.
- Flush: branch predicted taken in ID at N; hazard_signal=`FLUSH_ALL at N+1 edge -> jump_taken=0 at N+2. A simultaneous branch_resolved=1, actual_taken=1 still increments table[MEM.idx].
- Same-index collision: update entry 5 (01→10) and look up entry 5 in the same cycle -> predict_taken=0 that cycle, 1 the next.
- BP_GSHARE_EN: resolve taken, taken (GHR=000011); lookup pc 0x10 (pc idx 4) -> table index 7 accessed. A plain build accesses index 4.
